// File: rtl/mux_chan_scanner.sv
// mux_chan_scanner
// Drives the select of a downstream 4-to-1 channel mux, holds each enabled
// channel for dwell+1 cycles and captures the mux output on the last cycle
// of each window. The enabled channels are scanned in ascending order, and
// the captured bits are assembled into a 4-bit snapshot.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; S=00, sample keeps the last snapshot
// SCAN  | holding S on an enabled channel, counting the dwell window
// DONE  | one-cycle done pulse, then back to IDLE
module mux_chan_scanner #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               f_in,
  output logic [1:0]         S,
  output logic [3:0]         sample,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  logic [1:0]         first_ch;
  logic               nxt_found;
  logic [1:0]         nxt_ch;

  // Lowest enabled channel in the incoming mask (used at the start edge)
  always_comb begin
    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) first_ch = 2'(i);
    end
  end

  // Next higher enabled channel in the latched mask; no wrap-around
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > {1'b0, S})) begin
        nxt_found = 1'b1;
        nxt_ch    = 2'(i);
      end
    end
  end

  // Scan sequencer with registered outputs; counter clears on compare so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mask_q  <= 4'd0;
      dwell_q <= '0;
      cnt     <= '0;
      S       <= 2'd0;
      sample  <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          S    <= 2'd0;
          if (start) begin
            sample <= 4'd0;
            if (mask != 4'd0) begin
              mask_q  <= mask;
              dwell_q <= dwell;
              cnt     <= '0;
              S       <= first_ch;
              busy    <= 1'b1;
              state   <= ST_SCAN;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SCAN: begin
          if (cnt != dwell_q) begin
            cnt <= cnt + 1'b1;
          end else begin
            sample[S] <= f_in;
            cnt       <= '0;
            if (nxt_found) begin
              S <= nxt_ch;
            end else begin
              S     <= 2'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          S     <= 2'd0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          S     <= 2'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_chan_scanner.sv
// Scoreboard bench for mux_chan_scanner: the driver pushes the expected
// snapshot, done time and per-channel hold counts; the monitor checks them
// when done appears, plus select legality on every cycle.
module tb_mux_chan_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mask;
  logic [3:0] dwell;
  logic       f_in;
  logic [1:0] S;
  logic [3:0] sample;
  logic       busy;
  logic       done;

  logic [3:0] f_pat;
  assign f_in = f_pat[S];

  mux_chan_scanner #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mask(mask), .dwell(dwell),
    .f_in(f_in), .S(S), .sample(sample), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] smp;
    logic [3:0] msk;
    int         d;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   cnt[4];
  bit   prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        if (sb.size() == 0) check("busy_without_scan", 1, 0);
        else begin
          cnt[S]++;
          check("s_enabled", int'(sb[0].msk[S]), 1);
        end
      end else begin
        check("s_idle_zero", int'(S), 0);
      end
      if (done) begin
        check("done_width", int'(prev_done), 0);
        if (sb.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("sample", int'(sample), int'(e.smp));
          check("done_cycle", cyc, e.done_cyc);
          check("busy_at_done", int'(busy), 0);
          for (int c = 0; c < 4; c++) begin
            check($sformatf("hold_ch%0d", c), cnt[c], e.msk[c] ? e.d + 1 : 0);
            cnt[c] = 0;
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic run_scan(input logic [3:0] m, input int d, input logic [3:0] fp,
                          input bit perturb);
    exp_t x;
    int   k;
    @(negedge clk);
    f_pat = fp;
    mask  = m;
    dwell = d[3:0];
    start = 1'b1;
    k = $countones(m);
    x.smp = fp & m;
    x.msk = m;
    x.d = d;
    x.done_cyc = cyc + 1 + k * (d + 1);
    sb.push_back(x);
    @(negedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0) break;
      if (perturb) begin
        start = 1'($urandom);
        mask  = 4'($urandom);
        dwell = 4'($urandom);
      end
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check("scan_timeout", 1, 0);
      sb.delete();
    end
    start = 1'b0;
  endtask

  initial begin
    exp_t x;
    rst = 1'b1; start = 1'b0; mask = 4'd0; dwell = 4'd0; f_pat = 4'd0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    repeat (2) @(negedge clk);
    check("rst_S", int'(S), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    run_scan(4'b1111, 0, 4'b1101, 1'b0);
    run_scan(4'b1010, 2, 4'b1010, 1'b0);
    run_scan(4'b0000, 5, 4'b1111, 1'b0);
    run_scan(4'b0110, 1, 4'b0110, 1'b1);

    // Asynchronous reset during the second channel of a mask=1111, dwell=3 scan
    @(negedge clk);
    f_pat = 4'($urandom);
    mask = 4'b1111; dwell = 4'd3; start = 1'b1;
    x.smp = f_pat; x.msk = 4'b1111; x.d = 3; x.done_cyc = cyc + 1 + 16;
    sb.push_back(x);
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_S", int'(S), 0);
    check("midrst_sample", int'(sample), 0);
    check("midrst_busy", int'(busy), 0);
    sb.delete();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    prev_done = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;

    run_scan(4'b1111, 3, 4'($urandom), 1'b0);
    run_scan(4'b0001, 15, 4'b0001, 1'b0);

    for (int n = 0; n < 30; n++) begin
      run_scan(4'($urandom), int'($urandom_range(0, 6)), 4'($urandom),
               1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
